// File: rtl/packet_store_forward_fifo_pkg.sv
// packet_store_forward_fifo_pkg: shared beat type and default sizes for the store-and-forward FIFO
//   DEF_DATA_W / DEF_DEPTH : default payload width and FIFO depth
//   DEF_BEAT_W             : stored beat width (payload plus first/last flags)
//   beat_t                 : one stored beat at the default width
package packet_store_forward_fifo_pkg;
    localparam int DEF_DATA_W = 32;
    localparam int DEF_DEPTH  = 16;
    localparam int DEF_BEAT_W = DEF_DATA_W + 2;
    typedef struct packed {
        logic                  first;
        logic                  last;
        logic [DEF_DATA_W-1:0] payload;
    } beat_t;
endpackage

// File: rtl/packet_store_forward_fifo_if.sv
// packet_store_forward_fifo_if: rx/tx beat handshakes plus occupancy status of the packet FIFO
//   master : upstream/downstream side (drives rx beats and ready_tx, observes the rest)
//   slave  : FIFO side (accepts rx beats, presents tx head beat and occupancy counters)
interface packet_store_forward_fifo_if
    import packet_store_forward_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
);
    localparam int ADDR_W = $clog2(DEPTH);
    logic              valid_rx;
    logic              ready_rx;
    logic              first_rx;
    logic              last_rx;
    logic [DATA_W-1:0] payload_rx;
    logic              valid_tx;
    logic              ready_tx;
    logic              first_tx;
    logic              last_tx;
    logic [DATA_W-1:0] payload_tx;
    logic [ADDR_W:0]   level;
    logic [ADDR_W:0]   pkt_count;
    modport master (
        output valid_rx, first_rx, last_rx, payload_rx, ready_tx,
        input  ready_rx, valid_tx, first_tx, last_tx, payload_tx, level, pkt_count
    );
    modport slave (
        input  valid_rx, first_rx, last_rx, payload_rx, ready_tx,
        output ready_rx, valid_tx, first_tx, last_tx, payload_tx, level, pkt_count
    );
endinterface

// File: rtl/packet_store_forward_fifo_mem.sv
// packet_store_forward_fifo_mem: DEPTH x WIDTH beat RAM, one synchronous write port, one async read port
//   clk     : write clock
//   we_i    : write enable, waddr_i/wdata_i : write address/data
//   raddr_i : read address, rdata_o : combinational read data
module packet_store_forward_fifo_mem
    import packet_store_forward_fifo_pkg::*;
#(
    parameter int WIDTH = DEF_BEAT_W,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                     clk,
    input  logic                     we_i,
    input  logic [$clog2(DEPTH)-1:0] waddr_i,
    input  logic [WIDTH-1:0]         wdata_i,
    input  logic [$clog2(DEPTH)-1:0] raddr_i,
    output logic [WIDTH-1:0]         rdata_o
);
    logic [WIDTH-1:0] mem_q [DEPTH];
    always_ff @(posedge clk)
        if (we_i) mem_q[waddr_i] <= wdata_i;
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/packet_store_forward_fifo.sv
// packet_store_forward_fifo: store-and-forward packet buffer with an escape mode for oversize packets
//   clk   : clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : slave side of packet_store_forward_fifo_if (rx beats in, tx head beat out, level, pkt_count)
module packet_store_forward_fifo
    import packet_store_forward_fifo_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int DEPTH  = DEF_DEPTH
) (
    input logic                        clk,
    input logic                        rst_n,
    packet_store_forward_fifo_if.slave bus
);
    localparam int ADDR_W = $clog2(DEPTH);
    localparam logic [ADDR_W:0] FULL = (ADDR_W+1)'(DEPTH);

    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [ADDR_W:0]   level_q, level_d, pkt_q, pkt_d;
    logic              esc_q, esc_d, rel_q;
    logic [DATA_W+1:0] head;
    logic              push, pop;

    packet_store_forward_fifo_mem #(.WIDTH(DATA_W + 2), .DEPTH(DEPTH)) u_mem (
        .clk     (clk),
        .we_i    (push),
        .waddr_i (wr_ptr_q),
        .wdata_i ({bus.first_rx, bus.last_rx, bus.payload_rx}),
        .raddr_i (rd_ptr_q),
        .rdata_o (head)
    );

    // rel_q keeps ready_rx low until the first edge after reset release
    assign bus.ready_rx = rel_q & (level_q != FULL);
    // escape lets an oversize packet stream out before its last beat arrives
    assign bus.valid_tx = (level_q != '0) & ((pkt_q != '0) | esc_q);
    assign {bus.first_tx, bus.last_tx, bus.payload_tx} = head;
    assign bus.level     = level_q;
    assign bus.pkt_count = pkt_q;
    assign push = bus.valid_rx & bus.ready_rx;
    assign pop  = bus.valid_tx & bus.ready_tx;

    always_comb begin
        wr_ptr_d = wr_ptr_q + ADDR_W'(push);
        rd_ptr_d = rd_ptr_q + ADDR_W'(pop);
        level_d  = level_q + (ADDR_W+1)'(push) - (ADDR_W+1)'(pop);
        pkt_d    = pkt_q + (ADDR_W+1)'(push & bus.last_rx) - (ADDR_W+1)'(pop & bus.last_tx);
        // a full buffer holding no complete packet can only drain by cut-through; set beats clear
        esc_d    = (level_q == FULL && pkt_q == '0) ? 1'b1 : (pop & bus.last_tx) ? 1'b0 : esc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            pkt_q    <= '0;
            esc_q    <= 1'b0;
            rel_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            pkt_q    <= pkt_d;
            esc_q    <= esc_d;
            rel_q    <= 1'b1;
        end
    end
endmodule

// File: tb/tb_packet_store_forward_fifo.sv
// tb_packet_store_forward_fifo: randomized self-checking bench against a queue-based packet model
module tb_packet_store_forward_fifo;
    import packet_store_forward_fifo_pkg::*;
    localparam int D = DEF_DEPTH;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    int   checks = 0;
    int   failures = 0;
    beat_t q[$];
    beat_t log_q[$];
    bit   esc_m = 1'b0;
    bit   rel_m = 1'b0;
    bit   done = 1'b0;

    packet_store_forward_fifo_if bus ();
    packet_store_forward_fifo dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    always #5 clk = ~clk;

    function automatic int pkts_m();
        int n = 0;
        foreach (q[i]) n += int'(q[i].last);
        return n;
    endfunction
    function automatic bit exp_ready();
        return rel_m && q.size() != D;
    endfunction
    function automatic bit exp_valid();
        return q.size() != 0 && (pkts_m() != 0 || esc_m);
    endfunction

    task automatic chk(input string name, input longint act, input longint exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask
    task automatic timeout(input string name);
        checks++;
        failures++;
        $display("FAIL %s: timed out at %0t", name, $time);
    endtask

    // Model: packets are a queue of beats; complete packets = count of last flags held.
    initial forever begin
        bit push, pop, fz;
        beat_t h;
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            q.delete();
            esc_m = 1'b0;
            rel_m = 1'b0;
        end else begin
            push = bus.valid_rx && exp_ready();
            pop  = exp_valid() && bus.ready_tx;
            fz   = q.size() == D && pkts_m() == 0;
            h    = '0;
            if (pop) begin
                h = q.pop_front();
                log_q.push_back(h);
            end
            esc_m = fz ? 1'b1 : (pop && h.last) ? 1'b0 : esc_m;
            if (push) q.push_back('{bus.first_rx, bus.last_rx, bus.payload_rx});
            rel_m = 1'b1;
        end
    end

    initial forever begin
        @(negedge clk);
        #1;
        chk("ready_rx", longint'(bus.ready_rx), longint'(exp_ready()));
        chk("valid_tx", longint'(bus.valid_tx), longint'(exp_valid()));
        chk("level", longint'(bus.level), longint'(q.size()));
        chk("pkt_count", longint'(bus.pkt_count), longint'(pkts_m()));
        if (exp_valid())
            chk("head", longint'({bus.first_tx, bus.last_tx, bus.payload_tx}), longint'(q[0]));
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    task automatic send(input bit f, input bit l, input logic [31:0] p);
        int n = 0;
        bus.valid_rx = 1'b1;
        bus.first_rx = f;
        bus.last_rx = l;
        bus.payload_rx = p;
        while (!bus.ready_rx && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) timeout("send");
        @(negedge clk);
        bus.valid_rx = 1'b0;
    endtask

    task automatic wait_empty(output int n);
        n = 0;
        while (bus.level != 0 && n < 5000) begin
            @(negedge clk);
            n++;
        end
        if (n >= 5000) timeout("drain");
    endtask

    initial begin
        int n;
        bus.valid_rx = 1'b0;
        bus.first_rx = 1'b0;
        bus.last_rx = 1'b0;
        bus.payload_rx = '0;
        bus.ready_tx = 1'b0;
        #1 rst_n = 1'b0;

        // 1: reset holds everything idle despite push attempts
        @(negedge clk);
        bus.valid_rx = 1'b1;
        bus.first_rx = 1'b1;
        bus.last_rx = 1'b1;
        bus.payload_rx = 32'hDEAD;
        repeat (3) begin
            @(negedge clk);
            #2;
            chk("rst_ready", longint'(bus.ready_rx), 0);
            chk("rst_valid", longint'(bus.valid_tx), 0);
            chk("rst_level", longint'(bus.level), 0);
        end
        @(negedge clk);
        bus.valid_rx = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        #2 chk("ready_after_release", longint'(bus.ready_rx), 1);
        @(negedge clk);

        // 2: store-and-forward of a 4-beat packet
        bus.ready_tx = 1'b1;
        log_q.delete();
        send(1, 0, 32'hA0);
        send(0, 0, 32'hA1);
        send(0, 0, 32'hA2);
        chk("sf_hold", longint'(bus.valid_tx), 0);
        send(0, 1, 32'hA3);
        chk("sf_release", longint'(bus.valid_tx), 1);
        chk("sf_pkt1", longint'(bus.pkt_count), 1);
        wait_empty(n);
        chk("sf_pop_cycles", n, 4);
        chk("sf_pkt0", longint'(bus.pkt_count), 0);
        chk("sf_count", log_q.size(), 4);
        foreach (log_q[i]) begin
            chk("sf_payload", longint'(log_q[i].payload), 32'hA0 + i);
            chk("sf_first", longint'(log_q[i].first), longint'(i == 0));
            chk("sf_last", longint'(log_q[i].last), longint'(i == 3));
        end

        // 3: fill with 16 single-beat packets, then a single pop reopens rx
        bus.ready_tx = 1'b0;
        log_q.delete();
        for (int i = 0; i < 16; i++) send(1, 1, 32'h100 + i);
        chk("full_level", longint'(bus.level), 16);
        chk("full_pkts", longint'(bus.pkt_count), 16);
        chk("full_ready", longint'(bus.ready_rx), 0);
        bus.ready_tx = 1'b1;
        @(negedge clk);
        bus.ready_tx = 1'b0;
        chk("full_reopen", longint'(bus.ready_rx), 1);
        chk("full_level15", longint'(bus.level), 15);
        bus.ready_tx = 1'b1;
        wait_empty(n);
        chk("full_count", log_q.size(), 16);
        foreach (log_q[i]) chk("full_payload", longint'(log_q[i].payload), 32'h100 + i);

        // 4: 20-beat packet forces escape once the buffer is full
        bus.ready_tx = 1'b0;
        log_q.delete();
        fork
            for (int i = 0; i < 20; i++) send(i == 0, i == 19, 32'h200 + i);
            begin
                int k = 0;
                while (bus.level != 16 && k < 200) begin
                    @(negedge clk);
                    k++;
                end
                if (k >= 200) timeout("esc_fill");
                chk("esc_before", longint'(bus.valid_tx), 0);
                @(negedge clk);
                chk("esc_valid", longint'(bus.valid_tx), 1);
                bus.ready_tx = 1'b1;
            end
        join
        wait_empty(n);
        chk("esc_count", log_q.size(), 20);
        foreach (log_q[i]) chk("esc_payload", longint'(log_q[i].payload), 32'h200 + i);
        send(1, 0, 32'h300);
        chk("esc_cleared_hold", longint'(bus.valid_tx), 0);
        chk("esc_cleared_level", longint'(bus.level), 1);
        send(0, 1, 32'h301);
        chk("esc_next_release", longint'(bus.valid_tx), 1);
        wait_empty(n);

        // 5: push the last beat of B while popping the last beat of A
        bus.ready_tx = 1'b0;
        send(1, 1, 32'h400);
        send(1, 0, 32'h401);
        bus.valid_rx = 1'b1;
        bus.first_rx = 1'b0;
        bus.last_rx = 1'b1;
        bus.payload_rx = 32'h402;
        bus.ready_tx = 1'b1;
        @(negedge clk);
        bus.valid_rx = 1'b0;
        bus.ready_tx = 1'b0;
        chk("sim_level", longint'(bus.level), 2);
        chk("sim_pkts", longint'(bus.pkt_count), 1);
        bus.ready_tx = 1'b1;
        wait_empty(n);

        // 5b: random traffic with random backpressure, packets up to 24 beats
        fork
            begin
                int sent = 0;
                while (sent < 10000) begin
                    int len = $urandom_range(1, 24);
                    for (int j = 0; j < len; j++) begin
                        if ($urandom_range(0, 3) == 0) @(negedge clk);
                        send(j == 0, j == len - 1, $urandom);
                        sent++;
                    end
                end
                done = 1'b1;
            end
            begin
                int c = 0;
                while (!(done && bus.level == 0) && c < 80000) begin
                    @(negedge clk);
                    bus.ready_tx = $urandom_range(0, 2) != 0;
                    c++;
                end
                if (c >= 80000) timeout("random_drain");
            end
        join
        @(negedge clk);

        // 6: asynchronous reset with 7 beats stored
        bus.ready_tx = 1'b0;
        for (int i = 0; i < 7; i++) send(i == 0, 0, 32'h600 + i);
        chk("mid_level7", longint'(bus.level), 7);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_ready", longint'(bus.ready_rx), 0);
        chk("mid_rst_valid", longint'(bus.valid_tx), 0);
        chk("mid_rst_level", longint'(bus.level), 0);
        chk("mid_rst_pkts", longint'(bus.pkt_count), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        log_q.delete();
        bus.ready_tx = 1'b1;
        for (int i = 0; i < 3; i++) send(i == 0, i == 2, 32'h500 + i);
        wait_empty(n);
        chk("post_count", log_q.size(), 3);
        foreach (log_q[i]) chk("post_payload", longint'(log_q[i].payload), 32'h500 + i);

        @(negedge clk);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
